// File: rtl/uart_apb3_responder.sv
// rtl/uart_apb3_responder.sv - APB3 completer UART: 8N1 TX/RX with FIFOs, sticky errors and irq
module uart_apb3_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int BUS_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [BUS_WIDTH-1:0]  pwdata,
    output logic                  pready,
    output logic [BUS_WIDTH-1:0]  prdata,
    output logic                  pslverr,
    output logic                  tx_o,
    input  logic                  rx_i,
    output logic                  irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    logic [4:0]            ctrl_q, ctrl_d;
    logic [15:0]           div_q, div_d;
    logic                  overrun_q, overrun_d, frame_err_q, frame_err_d, irq_q, irq_d;

    logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem_d [FIFO_DEPTH];
    logic [PW-1:0]         tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
    uart_state_e           tx_state_q, tx_state_d;
    logic [15:0]           tx_tick_q, tx_tick_d, tx_reload_q, tx_reload_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [BW-1:0]         tx_bit_q, tx_bit_d;
    logic                  tx_out_q, tx_out_d;

    logic [DATA_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem_d [FIFO_DEPTH];
    logic [PW-1:0]         rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
    uart_state_e           rx_state_q, rx_state_d;
    logic [15:0]           rx_tick_q, rx_tick_d, rx_reload_q, rx_reload_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [BW-1:0]         rx_bit_q, rx_bit_d;
    logic                  rx_wait_q, rx_wait_d;
    logic [1:0]            rx_sync_q, rx_sync_d;

    logic       access, wr_data, rd_data, wr_status, wr_ctrl, wr_div;
    logic       tx_full, tx_empty, rx_full, rx_empty, tx_busy;
    logic       tx_push, tx_pop, tx_launch, rx_push, rx_pop, rx_ovf, rx_ferr, rx_s;
    logic [1:0] reg_sel;
    logic [6:0] status_w;
    logic       unused_bits;

    assign unused_bits = ^{paddr[ADDR_WIDTH-1:4], paddr[1:0], pwdata[BUS_WIDTH-1:16]};

    assign access    = pselx & penable;
    assign reg_sel   = paddr[3:2];
    assign wr_data   = access & pwrite & (reg_sel == 2'd0);
    assign rd_data   = access & ~pwrite & (reg_sel == 2'd0);
    assign wr_status = access & pwrite & (reg_sel == 2'd1);
    assign wr_ctrl   = access & pwrite & (reg_sel == 2'd2);
    assign wr_div    = access & pwrite & (reg_sel == 2'd3);

    assign tx_full  = (tx_cnt_q == DEPTH_C);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == DEPTH_C);
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_busy  = (tx_state_q != ST_IDLE);
    assign tx_push  = wr_data & ~tx_full;
    assign rx_pop   = rd_data & ~rx_empty;
    assign rx_s     = rx_sync_q[1];
    assign status_w = {frame_err_q, overrun_q, tx_busy, rx_full, rx_empty, tx_empty, tx_full};

    assign pready = access;
    assign tx_o   = tx_out_q;
    assign irq_o  = irq_q;

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            case (reg_sel)
                2'd0: begin
                    if (pwrite) begin
                        pslverr = tx_full;
                    end else if (rx_empty) begin
                        pslverr = 1'b1;
                    end else begin
                        prdata[DATA_WIDTH-1:0] = rx_mem_q[rx_rptr_q];
                    end
                end
                2'd1:    if (!pwrite) prdata[6:0]  = status_w;
                2'd2:    if (!pwrite) prdata[4:0]  = ctrl_q;
                default: if (!pwrite) prdata[15:0] = div_q;
            endcase
        end
    end

    // Register file, sticky flags, interrupt and FIFO bookkeeping
    always_comb begin
        ctrl_d = wr_ctrl ? pwdata[4:0] : ctrl_q;
        div_d  = div_q;
        if (wr_div) div_d = (pwdata[15:0] < 16'd2) ? 16'd2 : pwdata[15:0];

        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (wr_status && pwdata[5]) overrun_d   = 1'b0;
        if (wr_status && pwdata[6]) frame_err_d = 1'b0;
        if (rx_ovf)  overrun_d   = 1'b1;
        if (rx_ferr) frame_err_d = 1'b1;

        irq_d = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty) |
                (ctrl_q[4] & (overrun_q | frame_err_q));

        tx_mem_d  = tx_mem_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wptr_q] = pwdata[DATA_WIDTH-1:0];
            tx_wptr_d           = tx_wptr_q + 1'b1;
        end
        if (tx_pop) tx_rptr_d = tx_rptr_q + 1'b1;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase

        rx_mem_d  = rx_mem_q;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wptr_q] = rx_shift_q;
            rx_wptr_d           = rx_wptr_q + 1'b1;
        end
        if (rx_pop) rx_rptr_d = rx_rptr_q + 1'b1;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // TX FSM: a stop bit that ends with data queued launches the next start bit directly
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tick_d   = tx_tick_q;
        tx_reload_d = tx_reload_q;
        tx_shift_d  = tx_shift_q;
        tx_bit_d    = tx_bit_q;
        tx_out_d    = tx_out_q;
        tx_launch   = 1'b0;
        tx_pop      = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_out_d  = 1'b1;
                tx_launch = ctrl_q[0] & ~tx_empty;
            end
            ST_START: begin
                if (tx_tick_q == '0) begin
                    tx_state_d = ST_DATA;
                    tx_tick_d  = tx_reload_q - 16'd1;
                    tx_bit_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                end else begin
                    tx_tick_d = tx_tick_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_tick_q == '0) begin
                    tx_tick_d = tx_reload_q - 16'd1;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = ST_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_out_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_tick_d = tx_tick_q - 16'd1;
                end
            end
            default: begin
                if (tx_tick_q == '0) begin
                    tx_state_d = ST_IDLE;
                    tx_out_d   = 1'b1;
                    tx_launch  = ctrl_q[0] & ~tx_empty;
                end else begin
                    tx_tick_d = tx_tick_q - 16'd1;
                end
            end
        endcase
        if (tx_launch) begin
            tx_pop      = 1'b1;
            tx_state_d  = ST_START;
            tx_shift_d  = tx_mem_q[tx_rptr_q];
            tx_reload_d = div_q;
            tx_tick_d   = div_q - 16'd1;
            tx_out_d    = 1'b0;
        end
    end

    // RX FSM: samples mid-bit; after a framing error it holds in STOP until the line idles
    always_comb begin
        rx_sync_d   = {rx_sync_q[0], rx_i};
        rx_state_d  = rx_state_q;
        rx_tick_d   = rx_tick_q;
        rx_reload_d = rx_reload_q;
        rx_shift_d  = rx_shift_q;
        rx_bit_d    = rx_bit_q;
        rx_wait_d   = rx_wait_q;
        rx_push     = 1'b0;
        rx_ovf      = 1'b0;
        rx_ferr     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (ctrl_q[1] && !rx_s) begin
                    rx_state_d  = ST_START;
                    rx_reload_d = div_q;
                    rx_tick_d   = {1'b0, div_q[15:1]} - 16'd1;
                end
            end
            ST_START: begin
                if (rx_tick_q == '0) begin
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                    rx_tick_d  = rx_reload_q - 16'd1;
                    rx_bit_d   = '0;
                end else begin
                    rx_tick_d = rx_tick_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_tick_q == '0) begin
                    rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
                    rx_tick_d  = rx_reload_q - 16'd1;
                    if (rx_bit_q == LAST_BIT) rx_state_d = ST_STOP;
                    else                      rx_bit_d   = rx_bit_q + 1'b1;
                end else begin
                    rx_tick_d = rx_tick_q - 16'd1;
                end
            end
            default: begin
                if (rx_wait_q) begin
                    if (rx_s) begin
                        rx_wait_d  = 1'b0;
                        rx_state_d = ST_IDLE;
                    end
                end else if (rx_tick_q == '0) begin
                    if (!rx_s) begin
                        rx_ferr   = 1'b1;
                        rx_wait_d = 1'b1;
                    end else begin
                        rx_state_d = ST_IDLE;
                        if (rx_full && !rx_pop) rx_ovf  = 1'b1;
                        else                    rx_push = 1'b1;
                    end
                end else begin
                    rx_tick_d = rx_tick_q - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= 5'h03;
            div_q       <= 16'(DEFAULT_DIV);
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
                rx_mem_q[i] <= '0;
            end
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
            tx_state_q  <= ST_IDLE;
            tx_tick_q   <= '0;
            tx_reload_q <= '0;
            tx_shift_q  <= '0;
            tx_bit_q    <= '0;
            tx_out_q    <= 1'b1;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_cnt_q    <= '0;
            rx_state_q  <= ST_IDLE;
            rx_tick_q   <= '0;
            rx_reload_q <= '0;
            rx_shift_q  <= '0;
            rx_bit_q    <= '0;
            rx_wait_q   <= 1'b0;
            rx_sync_q   <= 2'b11;
        end else begin
            ctrl_q      <= ctrl_d;
            div_q       <= div_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
            tx_mem_q    <= tx_mem_d;
            rx_mem_q    <= rx_mem_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_reload_q <= tx_reload_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_out_q    <= tx_out_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_state_q  <= rx_state_d;
            rx_tick_q   <= rx_tick_d;
            rx_reload_q <= rx_reload_d;
            rx_shift_q  <= rx_shift_d;
            rx_bit_q    <= rx_bit_d;
            rx_wait_q   <= rx_wait_d;
            rx_sync_q   <= rx_sync_d;
        end
    end
endmodule

// File: tb/tb_uart_apb3_responder.sv
// tb/tb_uart_apb3_responder.sv - directed vector bench for uart_apb3_responder
module tb_uart_apb3_responder;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic        pselx = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        tx_o;
    logic        rx_i;
    logic        irq_o;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] frame_bytes [4];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    assign rx_i = loop_en ? tx_o : rx_drv;

    always #5 clk = ~clk;

    uart_apb3_responder #(
        .DATA_WIDTH(8), .ADDR_WIDTH(32), .BUS_WIDTH(32), .FIFO_DEPTH(4), .DEFAULT_DIV(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .paddr(paddr), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .tx_o(tx_o), .rx_i(rx_i), .irq_o(irq_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output logic rdy);
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = wd; pselx = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1;
        rd = prdata; err = pslverr; rdy = pready;
        @(posedge clk);
        #1;
        pselx = 1'b0; penable = 1'b0;
    endtask

    task automatic reg_rd(input string name, input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_e);
        logic [31:0] rd;
        logic        er, rdy;
        apb(1'b0, a, 32'h0, rd, er, rdy);
        check({name, "_data"}, rd, exp_d);
        check({name, "_err"}, {31'b0, er}, {31'b0, exp_e});
    endtask

    task automatic reg_wr(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_e);
        logic [31:0] rd;
        logic        er, rdy;
        apb(1'b1, a, d, rd, er, rdy);
        check({name, "_err"}, {31'b0, er}, {31'b0, exp_e});
    endtask

    function automatic logic exp_tx(input int k, input int n);
        int m, f, p;
        if (k == 0) return 1'b1;
        m = k - 1;
        if (m >= 10 * D * n) return 1'b1;
        f = m / (10 * D);
        p = (m % (10 * D)) / D;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return frame_bytes[f][p-1];
    endfunction

    // Called right after the access cycle that makes the transmitter go
    task automatic check_frames(input int n);
        for (int k = 0; k <= 10 * D * n + 1; k++) begin
            @(negedge clk);
            check($sformatf("tx_f%0d_k%0d", n, k), {31'b0, tx_o}, {31'b0, exp_tx(k, n)});
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx_drv = bits[i];
            repeat (D - 1) @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h4, 32'h0,        32'h06,   1'b0};
        vecs[1]  = '{1'b0, 32'hC, 32'h0,        32'd16,   1'b0};
        vecs[2]  = '{1'b0, 32'h8, 32'h0,        32'h03,   1'b0};
        vecs[3]  = '{1'b0, 32'h0, 32'h0,        32'h0,    1'b1};
        vecs[4]  = '{1'b1, 32'h8, 32'h1F,       32'h0,    1'b0};
        vecs[5]  = '{1'b0, 32'h8, 32'h0,        32'h1F,   1'b0};
        vecs[6]  = '{1'b1, 32'h8, 32'hFFFFFFE3, 32'h0,    1'b0};
        vecs[7]  = '{1'b0, 32'hB, 32'h0,        32'h03,   1'b0};
        vecs[8]  = '{1'b1, 32'hC, 32'h1,        32'h0,    1'b0};
        vecs[9]  = '{1'b0, 32'hC, 32'h0,        32'h02,   1'b0};
        vecs[10] = '{1'b1, 32'hC, 32'h12345,    32'h0,    1'b0};
        vecs[11] = '{1'b0, 32'hD, 32'h0,        32'h2345, 1'b0};
        vecs[12] = '{1'b1, 32'h4, 32'hFFFFFFFF, 32'h0,    1'b0};
        vecs[13] = '{1'b0, 32'h4, 32'h0,        32'h06,   1'b0};
        vecs[14] = '{1'b1, 32'hC, 32'h4,        32'h0,    1'b0};
        vecs[15] = '{1'b0, 32'hC, 32'h0,        32'h04,   1'b0};

        repeat (3) @(negedge clk);
        check("rst_tx_o", {31'b0, tx_o}, 32'h1);
        check("rst_irq", {31'b0, irq_o}, 32'h0);
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            logic [31:0] rd;
            logic        er, rdy;
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, rdy);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_rdy", i), {31'b0, rdy}, 32'h1);
            if (!vecs[i].wr) check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
        end

        frame_bytes[0] = 8'hA5;
        reg_wr("tx_a5", 32'h0, 32'hA5, 1'b0);
        check_frames(1);
        reg_rd("status_after_a5", 32'h4, 32'h06, 1'b0);

        loop_en = 1'b1;
        reg_wr("loop_3c", 32'h0, 32'h3C, 1'b0);
        repeat (60) @(negedge clk);
        reg_rd("status_loop", 32'h4, 32'h02, 1'b0);
        reg_rd("data_loop", 32'h0, 32'h3C, 1'b0);
        reg_rd("status_loop_empty", 32'h4, 32'h06, 1'b0);

        reg_wr("ctrl_txoff", 32'h8, 32'h02, 1'b0);
        reg_wr("fill1", 32'h0, 32'h11, 1'b0);
        reg_wr("fill2", 32'h0, 32'h22, 1'b0);
        reg_wr("fill3", 32'h0, 32'h33, 1'b0);
        reg_wr("fill4", 32'h0, 32'h44, 1'b0);
        reg_wr("fill5", 32'h0, 32'h55, 1'b1);
        reg_rd("status_txfull", 32'h4, 32'h05, 1'b0);
        frame_bytes[0] = 8'h11; frame_bytes[1] = 8'h22;
        frame_bytes[2] = 8'h33; frame_bytes[3] = 8'h44;
        reg_wr("ctrl_txon", 32'h8, 32'h03, 1'b0);
        check_frames(4);
        reg_rd("status_rxfull", 32'h4, 32'h0A, 1'b0);

        reg_wr("ovf_byte", 32'h0, 32'h66, 1'b0);
        repeat (60) @(negedge clk);
        reg_rd("status_ovf", 32'h4, 32'h2A, 1'b0);
        reg_wr("ctrl_errirq", 32'h8, 32'h13, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_ovf", {31'b0, irq_o}, 32'h1);
        reg_wr("w1c_ovf", 32'h4, 32'h20, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_cleared", {31'b0, irq_o}, 32'h0);
        reg_rd("status_ovf_clr", 32'h4, 32'h0A, 1'b0);
        reg_wr("ctrl_back", 32'h8, 32'h03, 1'b0);
        reg_rd("rx0", 32'h0, 32'h11, 1'b0);
        reg_rd("rx1", 32'h0, 32'h22, 1'b0);
        reg_rd("rx2", 32'h0, 32'h33, 1'b0);
        reg_rd("rx3", 32'h0, 32'h44, 1'b0);
        reg_rd("rx_empty_err", 32'h0, 32'h0, 1'b1);
        loop_en = 1'b0;

        send_rx(8'hC3, 1'b0);
        repeat (8) @(negedge clk);
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
        reg_rd("status_ferr", 32'h4, 32'h46, 1'b0);
        reg_wr("w1c_ferr", 32'h4, 32'h40, 1'b0);
        reg_rd("status_ferr_clr", 32'h4, 32'h06, 1'b0);
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        reg_rd("rx_after_ferr", 32'h0, 32'h5A, 1'b0);

        reg_wr("div8", 32'hC, 32'h8, 1'b0);
        @(negedge clk) rx_drv = 1'b0;
        @(negedge clk) rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        reg_rd("status_glitch", 32'h4, 32'h06, 1'b0);
        reg_rd("data_glitch", 32'h0, 32'h0, 1'b1);

        reg_wr("div4", 32'hC, 32'h4, 1'b0);
        reg_wr("tx_00", 32'h0, 32'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("tx_mid_low", {31'b0, tx_o}, 32'h0);
        reg_rd("status_busy", 32'h4, 32'h16, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("tx_async_rst", {31'b0, tx_o}, 32'h1);
        @(negedge clk) rst_n = 1'b1;
        reg_rd("status_post_rst", 32'h4, 32'h06, 1'b0);
        reg_rd("div_post_rst", 32'hC, 32'd16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
